// File: rtl/regex_ctrl_pkg.sv
// Shared definitions for the regex stream controller: FSM encoding and default parameters.
package regex_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      KICK   = 3'd1,
      WAIT   = 3'd2,
      REPORT = 3'd3,
      DONE   = 3'd4,
      ERROR  = 3'd5
   } state_t;

   localparam int unsigned DEF_KICK_CYCLES = 2;
   localparam int unsigned DEF_TIMEOUT     = 1024;
   localparam int unsigned DEF_POS_W       = 32;

   // Wide enough for the largest legal kick length (15).
   localparam int unsigned KICK_CNT_W      = 4;

endpackage

// File: rtl/regex_timeout_ctr.sv
// Counts cycles spent waiting on the engine; o_expire flags the final allowed cycle.
module regex_timeout_ctr
   import regex_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expire
);

   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] r_count;

   // r_count holds the number of enabled cycles already elapsed since the clear.
   assign o_expire = i_enable && (r_count == CW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable && !o_expire) begin
         r_count <= r_count + CW'(1);
      end
   end

endmodule

// File: rtl/regex_stream_controller.sv
// Per-character sequencer between a byte stream and an external compiled_regex engine:
// kicks the engine, waits for its verdict and forwards de-duplicated match positions.
module regex_stream_controller
   import regex_ctrl_pkg::*;
#(
   parameter int unsigned KICK_CYCLES = DEF_KICK_CYCLES,
   parameter int unsigned TIMEOUT     = DEF_TIMEOUT,
   parameter int unsigned POS_W       = DEF_POS_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             s_valid,
   input  logic [7:0]       s_data,
   input  logic             s_last,
   output logic             s_ready,
   output logic             eng_reset,
   output logic [7:0]       eng_char,
   output logic             eng_last,
   input  logic             eng_rdy,
   input  logic             eng_match,
   input  logic [POS_W-1:0] eng_start_pos,
   input  logic [POS_W-1:0] eng_end_pos,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [POS_W-1:0] m_start,
   output logic [POS_W-1:0] m_end,
   output logic             busy,
   output logic             done,
   output logic             timeout_err,
   output logic [POS_W-1:0] char_count
);

   state_t                r_state;
   state_t                w_next;
   logic [KICK_CNT_W-1:0] r_kick_cnt;
   logic                  r_rdy_arm;
   logic [7:0]            r_eng_char;
   logic                  r_eng_last;
   logic [POS_W-1:0]      r_char_count;
   logic [POS_W-1:0]      r_m_start;
   logic [POS_W-1:0]      r_m_end;
   logic [POS_W-1:0]      r_last_start;
   logic [POS_W-1:0]      r_last_end;
   logic                  r_last_vld;
   logic                  r_timeout_err;

   logic                  w_kick_end;
   logic                  w_rdy_take;
   logic                  w_new_pair;
   logic                  w_to_clear;
   logic                  w_to_en;
   logic                  w_expire;

   assign w_kick_end = (r_kick_cnt == KICK_CNT_W'(KICK_CYCLES - 1));
   // The engine result is trusted only from the second WAIT cycle onward.
   assign w_rdy_take = r_rdy_arm && eng_rdy;
   assign w_new_pair = eng_match &&
                       !(r_last_vld && (eng_start_pos == r_last_start) &&
                         (eng_end_pos == r_last_end));
   assign w_to_clear = (r_state != WAIT);
   assign w_to_en    = (r_state == WAIT);

   regex_timeout_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk      (clk),
      .reset    (reset),
      .i_clear  (w_to_clear),
      .i_enable (w_to_en),
      .o_expire (w_expire)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (s_valid) w_next = KICK;
         end
         KICK: begin
            if (w_kick_end) w_next = WAIT;
         end
         WAIT: begin
            if (w_rdy_take) begin
               if (w_new_pair)      w_next = REPORT;
               else if (r_eng_last) w_next = DONE;
               else                 w_next = IDLE;
            end else if (w_expire) begin
               w_next = ERROR;
            end
         end
         REPORT: begin
            if (m_ready) w_next = r_eng_last ? DONE : IDLE;
         end
         DONE:    w_next = DONE;
         ERROR:   w_next = ERROR;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      s_ready   = 1'b0;
      eng_reset = 1'b0;
      m_valid   = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (r_state)
         IDLE:   s_ready = 1'b1;
         KICK: begin
            eng_reset = 1'b1;
            busy      = 1'b1;
         end
         WAIT:   busy = 1'b1;
         REPORT: begin
            m_valid = 1'b1;
            busy    = 1'b1;
         end
         DONE:   done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_kick_cnt    <= '0;
         r_rdy_arm     <= 1'b0;
         r_eng_char    <= '0;
         r_eng_last    <= 1'b0;
         r_char_count  <= '0;
         r_m_start     <= '0;
         r_m_end       <= '0;
         r_last_start  <= '0;
         r_last_end    <= '0;
         r_last_vld    <= 1'b0;
         r_timeout_err <= 1'b0;
      end else begin
         r_kick_cnt <= (r_state == KICK) ? r_kick_cnt + KICK_CNT_W'(1) : '0;
         r_rdy_arm  <= (r_state == WAIT);
         if (r_state == IDLE && s_valid) begin
            r_eng_char   <= s_data;
            r_eng_last   <= s_last;
            r_char_count <= r_char_count + POS_W'(1);
         end
         if (r_state == WAIT && w_next == REPORT) begin
            r_m_start <= eng_start_pos;
            r_m_end   <= eng_end_pos;
         end
         // Only a handshaken report becomes the reference for de-duplication.
         if (r_state == REPORT && m_ready) begin
            r_last_start <= r_m_start;
            r_last_end   <= r_m_end;
            r_last_vld   <= 1'b1;
         end
         if (r_state == WAIT && w_next == ERROR) begin
            r_timeout_err <= 1'b1;
         end
      end
   end

   assign eng_char    = r_eng_char;
   assign eng_last    = r_eng_last;
   assign m_start     = r_m_start;
   assign m_end       = r_m_end;
   assign timeout_err = r_timeout_err;
   assign char_count  = r_char_count;

endmodule

// File: tb/tb_regex_stream_controller.sv
// Scoreboard bench for regex_stream_controller with a directed engine stub.
module tb_regex_stream_controller;

   localparam int KC = 3;
   localparam int TO = 16;
   localparam int PW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          s_valid;
   logic [7:0]    s_data;
   logic          s_last;
   logic          s_ready;
   logic          eng_reset;
   logic [7:0]    eng_char;
   logic          eng_last;
   logic          eng_rdy;
   logic          eng_match;
   logic [PW-1:0] eng_start_pos;
   logic [PW-1:0] eng_end_pos;
   logic          m_valid;
   logic          m_ready;
   logic [PW-1:0] m_start;
   logic [PW-1:0] m_end;
   logic          busy;
   logic          done;
   logic          timeout_err;
   logic [PW-1:0] char_count;

   typedef struct {
      bit          never;
      int          delay;
      bit          match;
      logic [31:0] sp;
      logic [31:0] ep;
   } stub_t;

   typedef struct {
      logic [31:0] s;
      logic [31:0] e;
   } rpt_t;

   stub_t      stub_q[$];
   rpt_t       exp_q[$];
   int         n_chk  = 0;
   int         n_fail = 0;
   logic [7:0] cur_char = 8'h00;
   logic       cur_last = 1'b0;
   int         kick_run = 0;

   always #5 clk = ~clk;

   regex_stream_controller #(
      .KICK_CYCLES (KC),
      .TIMEOUT     (TO),
      .POS_W       (PW)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .s_valid       (s_valid),
      .s_data        (s_data),
      .s_last        (s_last),
      .s_ready       (s_ready),
      .eng_reset     (eng_reset),
      .eng_char      (eng_char),
      .eng_last      (eng_last),
      .eng_rdy       (eng_rdy),
      .eng_match     (eng_match),
      .eng_start_pos (eng_start_pos),
      .eng_end_pos   (eng_end_pos),
      .m_valid       (m_valid),
      .m_ready       (m_ready),
      .m_start       (m_start),
      .m_end         (m_end),
      .busy          (busy),
      .done          (done),
      .timeout_err   (timeout_err),
      .char_count    (char_count)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic stub_t mk(input bit never, input int delay, input bit match,
                                input logic [31:0] sp, input logic [31:0] ep);
      stub_t e;
      e.never = never; e.delay = delay; e.match = match; e.sp = sp; e.ep = ep;
      return e;
   endfunction

   function automatic rpt_t rp(input logic [31:0] s, input logic [31:0] e);
      rpt_t r;
      r.s = s; r.e = e;
      return r;
   endfunction

   // Engine stub: one scripted response per kick, timed from eng_reset falling.
   initial begin
      eng_rdy = 1'b0; eng_match = 1'b0; eng_start_pos = '0; eng_end_pos = '0;
      forever begin
         stub_t e;
         @(negedge eng_reset);
         if (stub_q.size() != 0) begin
            e = stub_q.pop_front();
            if (!e.never) begin
               repeat (e.delay) @(posedge clk);
               #1;
               eng_rdy = 1'b1; eng_match = e.match; eng_start_pos = e.sp; eng_end_pos = e.ep;
               @(posedge clk);
               #1;
               eng_rdy = 1'b0; eng_match = 1'b0;
            end
         end
      end
   end

   // Monitor: report scoreboard, held-character stability and kick pulse width.
   always @(negedge clk) begin
      rpt_t r;
      if (reset) begin
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL unexpected_report: got (%0d,%0d), expected no report", m_start, m_end);
            end else begin
               r = exp_q.pop_front();
               chk("m_start", m_start, r.s);
               chk("m_end", m_end, r.e);
            end
         end
         if (busy) begin
            chk("eng_char_stable", eng_char, cur_char);
            chk("eng_last_stable", eng_last, cur_last);
         end
         if (eng_reset) kick_run++;
         else if (kick_run != 0) begin
            chk("kick_len", kick_run, KC);
            kick_run = 0;
         end
      end else begin
         kick_run = 0;
      end
   end

   task automatic send(input logic [7:0] c, input logic last);
      int n = 0;
      s_valid = 1'b1; s_data = c; s_last = last;
      @(negedge clk);
      while (!s_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!s_ready) begin
         n_chk++; n_fail++;
         $display("FAIL send_accept: got s_ready=0 for 200 cycles, expected 1");
         s_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      cur_char = c; cur_last = last;
      s_valid = 1'b0; s_last = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (!done && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk(name, done, 1);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      chk("rst_s_ready", s_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_timeout_err", timeout_err, 0);
      chk("rst_eng_reset", eng_reset, 0);
      chk("rst_char_count", char_count, 0);
      chk("rst_eng_char", eng_char, 0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   task automatic timeout_run(input stub_t e, input string tag);
      do_reset();
      stub_q.push_back(e);
      send(8'h41, 1'b0);
      repeat (KC) @(posedge clk);
      repeat (TO - 1) @(posedge clk);
      #1;
      chk({tag, "_not_yet"}, timeout_err, 0);
      chk({tag, "_busy"}, busy, 1);
      @(posedge clk);
      #1;
      chk({tag, "_timeout_err"}, timeout_err, 1);
      chk({tag, "_s_ready"}, s_ready, 0);
      chk({tag, "_busy_off"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      s_valid = 1'b1; s_data = 8'h42;
      repeat (5) @(posedge clk);
      #1;
      s_valid = 1'b0;
      chk({tag, "_terminal_count"}, char_count, 1);
      chk({tag, "_terminal_err"}, timeout_err, 1);
   endtask

   initial begin
      reset = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
      #3;
      do_reset();

      // "ab": no match on 'a', (0,1) on 'b'
      stub_q.push_back(mk(0, 1, 0, 0, 0));
      stub_q.push_back(mk(0, 2, 1, 0, 1));
      exp_q.push_back(rp(0, 1));
      send(8'h61, 1'b0);
      send(8'h62, 1'b1);
      wait_done("ab_done");
      chk("ab_char_count", char_count, 2);
      chk("ab_s_ready", s_ready, 0);
      chk("ab_reports", exp_q.size(), 0);

      // Same pair on three characters yields one report
      do_reset();
      for (int i = 0; i < 3; i++) stub_q.push_back(mk(0, 1 + i, 1, 2, 4));
      exp_q.push_back(rp(2, 4));
      send(8'h30, 1'b0);
      send(8'h31, 1'b0);
      send(8'h32, 1'b1);
      wait_done("dup_done");
      chk("dup_char_count", char_count, 3);
      chk("dup_reports", exp_q.size(), 0);

      // Back-pressure: report held while m_ready low
      do_reset();
      m_ready = 1'b0;
      stub_q.push_back(mk(0, 1, 1, 5, 9));
      exp_q.push_back(rp(5, 9));
      send(8'h7A, 1'b1);
      begin
         int n = 0;
         while (!eng_rdy && n < 100) begin
            @(negedge clk);
            n++;
         end
      end
      chk("lat_before", m_valid, 0);
      @(negedge clk);
      chk("lat_after", m_valid, 1);
      for (int i = 0; i < 20; i++) begin
         chk("hold_m_valid", m_valid, 1);
         chk("hold_m_start", m_start, 5);
         chk("hold_m_end", m_end, 9);
         chk("hold_s_ready", s_ready, 0);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      m_ready = 1'b1;
      wait_done("bp_done");
      chk("bp_reports", exp_q.size(), 0);

      // Engine silent, and engine answering only in the ignored first WAIT cycle
      timeout_run(mk(1, 0, 0, 0, 0), "to_never");
      timeout_run(mk(0, 0, 1, 3, 3), "to_early");

      // Reset in WAIT drops the character; the next one runs normally
      do_reset();
      stub_q.push_back(mk(0, 5, 1, 7, 7));
      send(8'h55, 1'b0);
      repeat (KC + 2) @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_s_ready", s_ready, 1);
      chk("midrst_m_valid", m_valid, 0);
      chk("midrst_char_count", char_count, 0);
      chk("midrst_eng_reset", eng_reset, 0);
      repeat (8) @(posedge clk);
      #1;
      reset = 1'b1;
      stub_q.push_back(mk(0, 2, 1, 1, 2));
      exp_q.push_back(rp(1, 2));
      send(8'h56, 1'b1);
      wait_done("midrst_done");
      chk("midrst_final_count", char_count, 1);

      repeat (2) @(negedge clk);
      chk("scoreboard_empty", exp_q.size(), 0);
      chk("stub_empty", stub_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
